// File: rtl/sh_pkg.sv
//------------------------------------------------------------------------------
// Module   : sh_pkg
// Brief    : Shared types and constants for the byte-to-halfword packer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sh_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [7:0]  DEF_PAD       = 8'h00;
  localparam logic [15:0] DEF_INIT_WORD = 16'h00AA;

  function automatic logic [15:0] pack_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : rr_arb2
// Brief    : Two-request combinational round-robin arbiter with one-hot grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sh_pack_arb.sv
//------------------------------------------------------------------------------
// Module   : sh_pack_arb
// Brief    : Round-robin byte packer: two byte streams into one 16-bit slot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sh_pack_arb
  import sh_pkg::*;
#(
  parameter logic [7:0]  PAD       = DEF_PAD,
  parameter logic [15:0] INIT_WORD = DEF_INIT_WORD,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [7:0]       b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             flush,
  output logic [15:0]      out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [15:0]       pack_q, pack_d;
  logic [15:0]       out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic [1:0] gnt;
  logic       slot_free;
  logic       load_word;
  logic [7:0] in_byte;
  logic [7:0] low_byte;

  // The high byte of the assembly register is shifted out and never read.
  logic unused_pack_hi;
  assign unused_pack_hi = ^pack_q[15:8];

  rr_arb2 u_arb (
    .req  ({b_valid, a_valid}),
    .last (last_owner_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    pack_d       = pack_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    word_cnt_d   = word_cnt_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    load_word    = 1'b0;
    in_byte      = 8'h00;
    low_byte     = PAD;
    slot_free    = !out_valid_q || out_ready;

    case (state_q)
      IDLE: begin
        // First byte only lands in the assembly register, so no slot needed.
        a_ready = gnt[0];
        b_ready = gnt[1];
        in_byte = gnt[1] ? b_data : a_data;
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
          pack_d  = {pack_q[7:0], in_byte};
          owner_d = gnt[1] ? SRC_B : SRC_A;
          state_d = HI;
        end
      end
      HI: begin
        a_ready = (owner_q == SRC_A) && slot_free;
        b_ready = (owner_q == SRC_B) && slot_free;
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
          load_word = 1'b1;
          low_byte  = (owner_q == SRC_B) ? b_data : a_data;
        end else if (flush && slot_free) begin
          load_word = 1'b1;
          low_byte  = PAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      out_data_d   = pack_bytes(pack_q[7:0], low_byte);
      out_src_d    = owner_q;
      out_valid_d  = 1'b1;
      last_owner_d = owner_q;
      word_cnt_d   = word_cnt_q + CNT_W'(1);
      state_d      = IDLE;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SRC_A;
      last_owner_q <= SRC_B;
      pack_q       <= INIT_WORD;
      out_data_q   <= 16'h0000;
      out_src_q    <= SRC_A;
      out_valid_q  <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pack_q       <= pack_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign word_cnt  = word_cnt_q;
  assign busy      = (state_q == HI) || out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sh_pack_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_sh_pack_arb
// Brief    : Directed self-checking bench for sh_pack_arb (16-bit and 2-bit counters).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sh_pack_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid, flush, out_ready;
  logic        a_ready, b_ready, out_src, out_valid, busy;
  logic [15:0] out_data;
  logic [15:0] word_cnt;

  logic        w_a_ready, w_b_ready, w_out_src, w_out_valid, w_busy;
  logic [15:0] w_out_data;
  logic [1:0]  w_word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sh_pack_arb dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .flush(flush),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .word_cnt(word_cnt)
  );

  sh_pack_arb #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(w_a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(w_b_ready),
    .flush(flush),
    .out_data(w_out_data), .out_src(w_out_src), .out_valid(w_out_valid), .out_ready(out_ready),
    .busy(w_busy), .word_cnt(w_word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks settle 1 more unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_data = 8'h00; b_data = 8'h00;
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_src",   out_src,   0);
    chk("rst_word_cnt",  word_cnt,  0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    step();

    // 1: single A word
    a_valid = 1'b1; a_data = 8'h12; settle();
    chk("t1_a_ready_hi", a_ready, 1);
    chk("t1_b_ready_lo", b_ready, 0);
    step();
    a_data = 8'h34; settle();
    chk("t1_busy_half", busy, 1);
    chk("t1_no_out_yet", out_valid, 0);
    chk("t1_b_ready_lo2", b_ready, 0);
    step();
    a_valid = 1'b0; settle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 16'h1234);
    chk("t1_out_src", out_src, 0);
    chk("t1_word_cnt", word_cnt, 1);
    chk("t1_wcnt_w", w_word_cnt, 1);
    step(); settle();
    chk("t1_out_drained", out_valid, 0);
    chk("t1_busy_idle", busy, 0);

    // 2: both streams continuously valid, A first after reset
    do_reset();
    a_valid = 1'b1; a_data = 8'hA1; b_valid = 1'b1; b_data = 8'hB1; settle();
    chk("t2_a_first", a_ready, 1);
    chk("t2_b_wait", b_ready, 0);
    step();
    a_data = 8'hA2; settle();
    chk("t2_b_locked_out", b_ready, 0);
    chk("t2_a_owner_ready", a_ready, 1);
    step();
    a_data = 8'hA3; settle();
    chk("t2_word_a", out_data, 16'hA1A2);
    chk("t2_src_a", out_src, 0);
    chk("t2_rr_b_turn", b_ready, 1);
    chk("t2_rr_a_wait", a_ready, 0);
    step();
    b_data = 8'hB2; settle();
    chk("t2_a_locked_out", a_ready, 0);
    chk("t2_b_owner_ready", b_ready, 1);
    step(); settle();
    chk("t2_word_b", out_data, 16'hB1B2);
    chk("t2_src_b", out_src, 1);
    chk("t2_cnt", word_cnt, 2);
    chk("t2_rr_a_turn", a_ready, 1);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // 3: backpressure on the output slot
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 8'h12;
    step();
    a_data = 8'h34;
    step();
    a_data = 8'h56; settle();
    chk("t3_pending", out_data, 16'h1234);
    chk("t3_first_ready", a_ready, 1);
    step();
    a_data = 8'h78; settle();
    chk("t3_stall_ready", a_ready, 0);
    step(); settle();
    chk("t3_stable_data", out_data, 16'h1234);
    chk("t3_stable_valid", out_valid, 1);
    chk("t3_still_stalled", a_ready, 0);
    chk("t3_cnt_hold", word_cnt, 3);
    out_ready = 1'b1; settle();
    chk("t3_unstall", a_ready, 1);
    step();
    a_valid = 1'b0; settle();
    chk("t3_new_word", out_data, 16'h5678);
    chk("t3_valid_kept", out_valid, 1);
    chk("t3_cnt", word_cnt, 4);
    step(); settle();
    chk("t3_drained", out_valid, 0);

    // 4: flush of a half word, then flush in IDLE
    a_valid = 1'b1; a_data = 8'h55;
    step();
    a_valid = 1'b0; flush = 1'b1; settle();
    chk("t4_busy", busy, 1);
    step();
    flush = 1'b0; settle();
    chk("t4_flush_data", out_data, 16'h5500);
    chk("t4_flush_src", out_src, 0);
    chk("t4_flush_cnt", word_cnt, 5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; settle();
    chk("t4_idle_flush_valid", out_valid, 0);
    chk("t4_idle_flush_cnt", word_cnt, 5);
    chk("t4_idle_flush_busy", busy, 0);

    // 5: asynchronous reset mid-word, then a B word
    a_valid = 1'b1; a_data = 8'hC3;
    step();
    a_valid = 1'b0; settle();
    chk("t5_busy_before", busy, 1);
    rst = 1'b1; settle();
    chk("t5_async_busy", busy, 0);
    chk("t5_async_cnt", word_cnt, 0);
    chk("t5_async_valid", out_valid, 0);
    step();
    rst = 1'b0;
    b_valid = 1'b1; b_data = 8'h01; settle();
    chk("t5_b_ready", b_ready, 1);
    step();
    b_data = 8'h02;
    step();
    b_valid = 1'b0; settle();
    chk("t5_word", out_data, 16'h0102);
    chk("t5_src", out_src, 1);
    chk("t5_cnt", word_cnt, 1);
    chk("t5_wcnt_w", w_word_cnt, 1);
    step();

    // 6: back-to-back words, 2-bit counter wraps 1,2,3,0,1
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'h20 + 8'(2 * i);
      step();
      a_data = 8'h21 + 8'(2 * i);
      step(); settle();
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, {8'h20 + 8'(2 * i), 8'h21 + 8'(2 * i)});
      chk("t6_cnt16", word_cnt, 32'(2 + i));
      chk("t6_cnt2", w_word_cnt, 32'((2 + i) % 4));
    end
    a_valid = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sh_pack_arb.md
Name: sh_pack_arb

Overview:
Two-requester byte-to-halfword packer built around the team's 8-bit-step, 16-bit shift-assembly register.
- Arbitrates round-robin between byte streams A and B.
- Holds the grant for both bytes of a word, so one word is never mixed from two sources.
- Shifts the two bytes into a 16-bit word and presents it on a one-entry valid/ready output slot, tagged with its source.
- Sits between byte-wide producers and 16-bit consumers in the shift-register datapath.

Parameters:
PAD, 8'h00, low byte inserted when a half-built word is flushed
INIT_WORD, 16'h00AA, reset value of the internal assembly register
CNT_W, 16, width of the completed-word counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
a_data  input  8  requester A byte
a_valid  input  1  A byte present
a_ready  output  1  A byte accepted this cycle when a_valid is also high
b_data  input  8  requester B byte
b_valid  input  1  B byte present
b_ready  output  1  B byte accepted this cycle when b_valid is also high
flush  input  1  complete a half-built word using PAD
out_data  output  16  packed word {first byte, second byte}
out_src  output  1  source of out_data (0 = A, 1 = B)
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
busy  output  1  half-built word pending, or out_valid high
word_cnt  output  CNT_W  words emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - pack_reg = INIT_WORD
  - state = IDLE
  - owner = 0
  - last_owner = 1, so A has priority first after reset
  - out_data = 0, out_src = 0, out_valid = 0, word_cnt = 0
  - reset mid-word discards the partial byte and any pending output word
- slot_free = !out_valid || out_ready.
- State IDLE (no partial word):
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester != last_owner.
  - The granted ready is high regardless of slot_free; the other ready is low.
  - On accept: pack_reg <= {pack_reg[7:0], byte}, owner <= grantee, state <= HI.
- State HI (high byte held in pack_reg[7:0]):
  - Only the owner's ready may be high, and it equals slot_free. The non-owner's ready is 0.
  - On owner accept: out_data <= {pack_reg[7:0], byte}, out_src <= owner, out_valid <= 1, last_owner <= owner, word_cnt++, state <= IDLE.
  - flush with no owner accept in the same cycle, and slot_free: same update, with PAD as the low byte.
  - flush while !slot_free: no effect. flush must be re-asserted later.
  - Owner byte and flush in the same cycle: the byte wins and flush is ignored.
- flush in IDLE: no-op.
- Output slot:
  - out_valid clears when out_ready is high and no new word loads that cycle.
  - If a new word loads while the old one drains, out_valid stays 1 and out_data updates.
  - out_data and out_src are stable while out_valid && !out_ready.
- Timing:
  - Latency: second byte accepted at edge N -> out_valid high after edge N.
  - Throughput: one word per 2 cycles with no backpressure.
- ready outputs are combinational from state, owner, last_owner, the valids and out_ready. There is no combinational path from data inputs.
- busy = (state == HI) || out_valid.
- word_cnt wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package sh_pkg:
  - state enum {IDLE, HI}
  - source id constants SRC_A = 0, SRC_B = 1
  - default PAD and INIT_WORD constants
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - Purely combinational. last_owner stays in sh_pack_arb.

Test Plan:
1. Reset, out_ready = 1, A sends 8'h12 then 8'h34 -> out_data 16'h1234, out_src 0, out_valid for 1 cycle, word_cnt 1, b_ready low throughout.
2. A and B both continuously valid (A: 8'hA1, 8'hA2; B: 8'hB1, 8'hB2) -> words 16'hA1A2 (src 0) then 16'hB1B2 (src 1); no interleaved bytes; b_ready = 0 while A owns.
3. out_ready = 0 with word 16'h1234 pending, A sends 8'h56 then 8'h78 -> 8'h56 accepted, a_ready = 0 on 8'h78 until out_ready = 1; then 16'h5678 loads in the same cycle 16'h1234 drains.
4. A sends 8'h55, flush pulses next cycle -> out_data 16'h5500, src 0, word_cnt +1. flush in IDLE -> no output, word_cnt unchanged.
5. rst asserted after high byte 8'hC3 accepted -> out_valid, busy, word_cnt all 0 immediately (asynchronous). Then B sends 8'h01, 8'h02 -> 16'h0102, src 1.
6. CNT_W = 2, emit 5 words -> word_cnt sequence 1, 2, 3, 0, 1.
